// File: rtl/pc_branch_if.sv
// pc_branch_if -- control/status bundle between the program-counter block
// and its decode stage.
//   slave  (pc_branch side): decision inputs in, PC / status out
//   master (decode side)   : decision inputs out, PC / status in
// Signals: stall_i, halt_i, branch_eq_i, branch_ne_i, zero_i, jump_i,
//          offset_sll_i[31:0], jump_target_i[31:0] (decode -> PC)
//          pc_o[31:0], pc_plus4_o[31:0], branch_taken_o, halted_o
//          (PC -> decode), branch_count_o[15:0] when PC_BRANCH_STATS_EN.
interface pc_branch_if;
  logic        stall_i;
  logic        halt_i;
  logic        branch_eq_i;
  logic        branch_ne_i;
  logic        zero_i;
  logic        jump_i;
  logic [31:0] offset_sll_i;
  logic [31:0] jump_target_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        branch_taken_o;
  logic        halted_o;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] branch_count_o;
`endif

  modport slave (
    input  stall_i, halt_i, branch_eq_i, branch_ne_i, zero_i, jump_i,
    input  offset_sll_i, jump_target_i,
    output pc_o, pc_plus4_o, branch_taken_o, halted_o
`ifdef PC_BRANCH_STATS_EN
    , output branch_count_o
`endif
  );

  modport master (
    output stall_i, halt_i, branch_eq_i, branch_ne_i, zero_i, jump_i,
    output offset_sll_i, jump_target_i,
    input  pc_o, pc_plus4_o, branch_taken_o, halted_o
`ifdef PC_BRANCH_STATS_EN
    , input branch_count_o
`endif
  );
endinterface

// File: rtl/pc_branch.sv
// pc_branch -- program counter with beq/bne/jump selection and a
// RUN/HOLD/HALT control FSM. HALT is left only through reset.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset (pc_o <= RESET_PC, state RUN)
//   bus    pc_branch_if.slave (decision inputs, pc_o, pc_plus4_o,
//          branch_taken_o, halted_o)
// Parameters: RESET_PC (reset PC), PC_INC (sequential increment).
// Optional macro PC_BRANCH_STATS_EN adds bus.branch_count_o, a 16-bit
// wrapping count of cycles in which branch_taken_o is set.
module pc_branch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input logic     clk_i,
  input logic     rst_i,
  pc_branch_if.slave bus
);

  typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        cond_taken;
  logic        taken_r, taken_nxt;
  logic        halted_r;

  // All additions wrap modulo 2^32; the carry is simply dropped.
  assign pc_plus4      = pc + 32'(PC_INC);
  assign branch_target = pc_plus4 + bus.offset_sll_i;

  // beq and bne asserted together is treated as "no branch".
  assign cond_taken = (bus.branch_eq_i ^ bus.branch_ne_i) &
                      ((bus.branch_eq_i & bus.zero_i) |
                       (bus.branch_ne_i & ~bus.zero_i));

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    taken_nxt = 1'b0;
    case (state)
      RUN, HOLD: begin
        if (bus.halt_i) begin
          state_nxt = HALT;
        end else if (bus.stall_i) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = RUN;
          if (bus.jump_i) begin
            pc_nxt    = bus.jump_target_i;
            taken_nxt = 1'b1;
          end else if (cond_taken) begin
            pc_nxt    = branch_target;
            taken_nxt = 1'b1;
          end else begin
            pc_nxt    = pc_plus4;
          end
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      pc       <= RESET_PC;
      taken_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      taken_r  <= taken_nxt;
      halted_r <= (state_nxt == HALT);
    end
  end

  assign bus.pc_o           = pc;
  assign bus.pc_plus4_o     = pc_plus4;
  assign bus.branch_taken_o = taken_r;
  assign bus.halted_o       = halted_r;

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] count;

  // Counts on the same edge that raises branch_taken_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (taken_nxt) begin
      count <= count + 16'd1;
    end
  end

  assign bus.branch_count_o = count;
`endif

endmodule

// File: doc/pc_branch.md
PC_BRANCH -- requirements
Module: pc_branch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter PC_INC, default 4: sequential PC increment.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 stall_i  input  1  hold the PC this cycle.
REQ-006 halt_i  input  1  enter HALT at the next edge.
REQ-007 branch_eq_i  input  1  current instruction is beq.
REQ-008 branch_ne_i  input  1  current instruction is bne.
REQ-009 zero_i  input  1  ALU zero flag for the current instruction.
REQ-010 jump_i  input  1  current instruction is an unconditional jump.
REQ-011 offset_sll_i  input  32  sign-extended branch offset, already shifted left by one bit upstream.
REQ-012 jump_target_i  input  32  absolute jump address.
REQ-013 pc_o  output  32  registered program counter.
REQ-014 pc_plus4_o  output  32  combinational pc_o + PC_INC.
REQ-015 branch_taken_o  output  1  registered; high for the one cycle after a taken branch or jump.
REQ-016 halted_o  output  1  registered; high while in HALT.

Function
REQ-017 Branch target SHALL be pc_plus4_o + offset_sll_i, computed modulo 2^32 (32-bit wrap-around, carry discarded).
REQ-018 pc_plus4_o SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-019 Branch condition SHALL be taken = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i) when exactly one of branch_eq_i/branch_ne_i is high; with both high, no branch SHALL be taken.
REQ-020 The state machine SHALL have three states: RUN, HOLD, HALT.
REQ-021 Next-PC priority in RUN/HOLD: halt_i > stall_i > jump_i > taken branch > pc_plus4_o.
REQ-022 From RUN or HOLD with halt_i=1: go to HALT; pc_o holds; halted_o=1 from the next cycle.
REQ-023 From RUN or HOLD with halt_i=0 and stall_i=1: go to HOLD; pc_o holds; branch_taken_o=0.
REQ-024 From RUN or HOLD with halt_i=0 and stall_i=0: go to RUN; pc_o loads jump_target_i, the branch target, or pc_plus4_o per REQ-021.
REQ-025 When pc_o loads jump_target_i or the branch target, branch_taken_o SHALL be 1 in the next cycle, else 0.
REQ-026 HALT SHALL be left only by reset; all inputs are ignored; pc_o holds; branch_taken_o=0.
REQ-027 Latency: decision inputs are sampled at edge N; the new pc_o is visible after edge N.
REQ-028 jump_i together with a taken branch: the jump wins and branch_taken_o=1.

Reset
REQ-029 On rst_i=1, immediately and regardless of clock: pc_o=RESET_PC, state=RUN, branch_taken_o=0, halted_o=0.
REQ-030 Reset asserted mid-HOLD or mid-HALT SHALL abort the state with no pending update applied after release.
REQ-031 On the first rising edge after rst_i falls, normal RUN decoding per REQ-024 applies.

Configuration
REQ-032 Macro PC_BRANCH_STATS_EN: when defined, add output branch_count_o (16 bits), which increments by 1 per cycle in which branch_taken_o is set, wraps 16'hFFFF->0, and resets to 0; when undefined, the port and counter are absent and behaviour is otherwise identical.

Verification
REQ-033 Reset then 3 idle cycles -> pc_o = 0, 4, 8, 12; branch_taken_o = 0.
REQ-034 pc_o=0x100, branch_eq_i=1, zero_i=1, offset_sll_i=0x20 -> pc_o=0x124 next cycle, branch_taken_o=1 for one cycle; same with zero_i=0 -> pc_o=0x104.
REQ-035 pc_o=0x200, jump_i=1, jump_target_i=0x40, branch_ne_i=1, zero_i=0 -> pc_o=0x40, branch_taken_o=1; both branch_eq_i and branch_ne_i high, no jump -> pc_o=0x204.
REQ-036 stall_i high for 2 cycles at pc_o=0x10 -> pc_o stays 0x10, then 0x14 after release; halt_i and stall_i together -> HALT, halted_o=1, pc_o frozen despite jump_i.
REQ-037 pc_o=0xFFFF_FFFC idle -> 0x0000_0000; offset_sll_i=0xFFFF_FFF8 at pc_o=0x8 with a taken branch -> pc_o=0x4.
REQ-038 rst_i pulsed asynchronously between edges while halted -> pc_o=RESET_PC and halted_o=0 immediately; with PC_BRANCH_STATS_EN, 3 taken branches -> branch_count_o=3, then 0 after reset.
